// File: rtl/dlx_periph_pkg.sv
// Shared peripheral constants for the DLX memory-mapped I/O slaves.
// The button block's register offsets, debounce default and popcount helper live here.
package dlx_periph_pkg;

    localparam int unsigned BTN_DEBOUNCE_DEFAULT = 50000;
    localparam int unsigned BTN_NUM_KEYS         = 4;
    localparam int unsigned BTN_COUNT_W          = 16;

    localparam logic [3:0] BTN_OFS_STATE = 4'h0;
    localparam logic [3:0] BTN_OFS_EDGE  = 4'h4;
    localparam logic [3:0] BTN_OFS_MASK  = 4'h8;
    localparam logic [3:0] BTN_OFS_COUNT = 4'hC;

    // Number of simultaneous press events in one cycle (0..4).
    function automatic logic [2:0] popcount4(input logic [3:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < 4; i++) begin
            n = n + 3'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/debounce.sv
// One push-button channel: 2-flop synchronizer, inversion to pressed=1, and
// a stability counter that accepts a new level after DEBOUNCE_CYCLES matching cycles.
module debounce
    import dlx_periph_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic pressed,
    output logic press_c
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic             sync1_q;
    logic             sync2_q;
    logic             deb_q;
    logic             deb_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Counter restarts whenever the synced level agrees with the accepted one.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= ~key_n;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pressed = deb_q;
    // Press pulse is aligned with the edge that updates the debounced bit.
    assign press_c = deb_d & ~deb_q;

endmodule

// File: rtl/driver_buttons.sv
// Memory-mapped push-button peripheral: debounced STATE, sticky EDGE (W1C),
// interrupt MASK, and a 16-bit press COUNT, with a registered interrupt.
module driver_buttons
    import dlx_periph_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  key,
    input  logic        chip_select,
    input  logic [31:0] address,
    input  logic        write_enable,
    input  logic [31:0] data_write,
    output logic [31:0] data_read,
    output logic        irq
);

    logic [3:0]             state_c;
    logic [3:0]             press_c;
    logic [3:0]             edge_q;
    logic [3:0]             edge_d;
    logic [3:0]             mask_q;
    logic [3:0]             mask_d;
    logic [BTN_COUNT_W-1:0] count_q;
    logic [BTN_COUNT_W-1:0] count_d;
    logic                   irq_q;
    logic                   irq_d;
    logic                   wr_c;
    logic [3:0]             ofs_c;
    logic                   unused_bits;

    for (genvar g = 0; g < BTN_NUM_KEYS; g++) begin : g_key
        debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk     (clk),
            .reset   (reset),
            .key_n   (key[g]),
            .pressed (state_c[g]),
            .press_c (press_c[g])
        );
    end

    assign wr_c  = chip_select && write_enable;
    assign ofs_c = {address[3:2], 2'b00};

    // Register update: new press events take priority over a W1C or COUNT write.
    always_comb begin
        edge_d  = edge_q;
        mask_d  = mask_q;
        count_d = count_q + BTN_COUNT_W'(popcount4(press_c));
        irq_d   = |(edge_q & mask_q);
        if (wr_c) begin
            case (ofs_c)
                BTN_OFS_EDGE:  edge_d  = edge_q & ~data_write[3:0];
                BTN_OFS_MASK:  mask_d  = data_write[3:0];
                BTN_OFS_COUNT: count_d = BTN_COUNT_W'(popcount4(press_c));
                default:       ;
            endcase
        end
        edge_d = edge_d | press_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            edge_q  <= '0;
            mask_q  <= '0;
            count_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            edge_q  <= edge_d;
            mask_q  <= mask_d;
            count_q <= count_d;
            irq_q   <= irq_d;
        end
    end

    always_comb begin
        data_read = '0;
        if (chip_select) begin
            case (ofs_c)
                BTN_OFS_STATE: data_read = 32'(state_c);
                BTN_OFS_EDGE:  data_read = 32'(edge_q);
                BTN_OFS_MASK:  data_read = 32'(mask_q);
                BTN_OFS_COUNT: data_read = 32'(count_q);
                default:       data_read = '0;
            endcase
        end
    end

    assign irq = irq_q;

    assign unused_bits = ^{address[31:4], address[1:0], data_write[31:4]};

endmodule

// File: tb/tb_driver_buttons.sv
// Directed bench for driver_buttons: main instance at DEBOUNCE_CYCLES=4, plus a
// DEBOUNCE_CYCLES=2 instance used to drive COUNT through 0xFFFF by real presses.
module tb_driver_buttons;

    localparam logic [1:0] R_STATE = 2'd0;
    localparam logic [1:0] R_EDGE  = 2'd1;
    localparam logic [1:0] R_MASK  = 2'd2;
    localparam logic [1:0] R_COUNT = 2'd3;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  key;
    logic        chip_select;
    logic [31:0] address;
    logic        write_enable;
    logic [31:0] data_write;
    logic [31:0] data_read;
    logic        irq;

    logic [3:0]  key2;
    logic        cs2;
    logic [31:0] address2;
    logic        we2;
    logic [31:0] wdata2;
    logic [31:0] rdata2;
    logic        irq2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    driver_buttons #(.DEBOUNCE_CYCLES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .key          (key),
        .chip_select  (chip_select),
        .address      (address),
        .write_enable (write_enable),
        .data_write   (data_write),
        .data_read    (data_read),
        .irq          (irq)
    );

    driver_buttons #(.DEBOUNCE_CYCLES(2)) dut_fast (
        .clk          (clk),
        .reset        (reset),
        .key          (key2),
        .chip_select  (cs2),
        .address      (address2),
        .write_enable (we2),
        .data_write   (wdata2),
        .data_read    (rdata2),
        .irq          (irq2)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [1:0] sel, output logic [31:0] v);
        chip_select = 1'b1;
        address     = {28'h0, sel, 2'b00};
        #1;
        v           = data_read;
        chip_select = 1'b0;
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] sel, input logic [31:0] exp);
        logic [31:0] v;
        rd(sel, v);
        check(tag, v, exp);
    endtask

    task automatic wr(input logic [1:0] sel, input logic [31:0] d);
        chip_select  = 1'b1;
        write_enable = 1'b1;
        address      = {28'h0, sel, 2'b00};
        data_write   = d;
        @(posedge clk);
        @(negedge clk);
        chip_select  = 1'b0;
        write_enable = 1'b0;
    endtask

    task automatic chk_reg2(input string tag, input logic [1:0] sel, input logic [31:0] exp);
        logic [31:0] v;
        cs2      = 1'b1;
        address2 = {28'h0, sel, 2'b00};
        #1;
        v        = rdata2;
        cs2      = 1'b0;
        check(tag, v, exp);
    endtask

    task automatic wr2(input logic [1:0] sel, input logic [31:0] d);
        cs2      = 1'b1;
        we2      = 1'b1;
        address2 = {28'h0, sel, 2'b00};
        wdata2   = d;
        @(posedge clk);
        @(negedge clk);
        cs2      = 1'b0;
        we2      = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        key          = 4'hF;
        chip_select  = 1'b0;
        address      = '0;
        write_enable = 1'b0;
        data_write   = '0;
        key2         = 4'hF;
        cs2          = 1'b0;
        address2     = '0;
        we2          = 1'b0;
        wdata2       = '0;
        tick(2);
        reset = 1'b0;

        // Reset state and idle read data
        check("rd_no_cs", data_read, 32'h0);
        chk_reg("rst_state", R_STATE, 32'h0);
        chk_reg("rst_edge",  R_EDGE,  32'h0);
        chk_reg("rst_mask",  R_MASK,  32'h0);
        chk_reg("rst_count", R_COUNT, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);

        // key[1] held: STATE changes exactly 6 cycles after the key change
        key = 4'hD;
        tick(5);
        chk_reg("k1_state_early", R_STATE, 32'h0);
        tick(1);
        chk_reg("k1_state", R_STATE, 32'h2);
        chk_reg("k1_edge",  R_EDGE,  32'h2);
        chk_reg("k1_count", R_COUNT, 32'h1);
        tick(4);
        key = 4'hF;
        tick(8);
        chk_reg("k1_rel_state", R_STATE, 32'h0);
        chk_reg("k1_rel_edge",  R_EDGE,  32'h2);
        chk_reg("k1_rel_count", R_COUNT, 32'h1);
        wr(R_EDGE, 32'h2);
        chk_reg("edge_w1c", R_EDGE, 32'h0);
        wr(R_COUNT, 32'h1234);
        chk_reg("count_wr_clr", R_COUNT, 32'h0);
        wr(R_STATE, 32'hF);
        chk_reg("state_ro", R_STATE, 32'h0);

        // 3-cycle glitch on key[0] is rejected
        key = 4'hE;
        tick(3);
        key = 4'hF;
        tick(10);
        chk_reg("glitch_state", R_STATE, 32'h0);
        chk_reg("glitch_edge",  R_EDGE,  32'h0);
        chk_reg("glitch_count", R_COUNT, 32'h0);

        // MASK + irq timing on key[2]
        wr(R_MASK, 32'hFFFF_FFF4);
        chk_reg("mask_rd", R_MASK, 32'h4);
        key = 4'hB;
        tick(6);
        chk_reg("k2_edge", R_EDGE, 32'h4);
        check("k2_irq_lag", {31'h0, irq}, 32'h0);
        tick(1);
        check("k2_irq", {31'h0, irq}, 32'h1);
        wr(R_EDGE, 32'h4);
        chk_reg("k2_edge_clr", R_EDGE, 32'h0);
        check("k2_irq_hold", {31'h0, irq}, 32'h1);
        tick(1);
        check("k2_irq_fall", {31'h0, irq}, 32'h0);
        key = 4'hF;
        tick(8);
        wr(R_MASK, 32'h0);

        // W1C collides with a key[0] press: the set wins
        key = 4'hE;
        tick(5);
        wr(R_EDGE, 32'h1);
        chk_reg("coll_edge",  R_EDGE,  32'h1);
        chk_reg("coll_state", R_STATE, 32'h1);
        chk_reg("coll_count", R_COUNT, 32'h2);
        key = 4'hF;
        tick(8);

        // Reset mid-debounce of key[3], key still held afterwards
        wr(R_MASK, 32'hF);
        tick(1);
        check("pre_rst_irq", {31'h0, irq}, 32'h1);
        key = 4'h7;
        tick(4);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk_reg("mid_rst_state", R_STATE, 32'h0);
        chk_reg("mid_rst_edge",  R_EDGE,  32'h0);
        chk_reg("mid_rst_mask",  R_MASK,  32'h0);
        chk_reg("mid_rst_count", R_COUNT, 32'h0);
        check("mid_rst_irq", {31'h0, irq}, 32'h0);
        tick(5);
        chk_reg("k3_state_early", R_STATE, 32'h0);
        tick(1);
        chk_reg("k3_state", R_STATE, 32'h8);
        chk_reg("k3_count", R_COUNT, 32'h1);
        chk_reg("k3_edge",  R_EDGE,  32'h8);
        key = 4'hF;

        // COUNT wrap: 16383 rounds of 4 presses + one round of 3 presses = 0xFFFF
        for (int i = 0; i < 16383; i++) begin
            key2 = 4'h0;
            tick(2);
            key2 = 4'hF;
            tick(2);
        end
        key2 = 4'h8;
        tick(2);
        key2 = 4'hF;
        tick(6);
        chk_reg2("wrap_pre_count", R_COUNT, 32'hFFFF);
        chk_reg2("wrap_pre_state", R_STATE, 32'h0);
        chk_reg2("wrap_pre_edge",  R_EDGE,  32'hF);
        wr2(R_EDGE, 32'hF);
        key2 = 4'h6;
        tick(3);
        chk_reg2("wrap_early_count", R_COUNT, 32'hFFFF);
        tick(1);
        chk_reg2("wrap_count", R_COUNT, 32'h1);
        chk_reg2("wrap_edge",  R_EDGE,  32'h9);
        chk_reg2("wrap_state", R_STATE, 32'h9);
        check("wrap_irq_masked", {31'h0, irq2}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
